// File: rtl/simd_encoder.sv
// Instruction field encoder feeding a small encoded-word FIFO with an
// auto-incrementing instruction-memory address and illegal-type accounting.
module simd_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               type_instruction,
  input  logic [4:0]               regnum_1,
  input  logic [4:0]               regnum_2,
  input  logic [4:0]               dest_reg,
  input  logic [5:0]               shammt,
  input  logic [8:0]               address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     illegal_pulse,
  output logic [7:0]               illegal_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] T_NOP  = 3'b000;
  localparam logic [2:0] T_SUB  = 3'b001;
  localparam logic [2:0] T_MUL  = 3'b010;
  localparam logic [2:0] T_ADD  = 3'b011;
  localparam logic [2:0] T_FADD = 3'b100;
  localparam logic [2:0] T_FSUB = 3'b101;
  localparam logic [2:0] T_LOAD = 3'b110;
  localparam logic [2:0] T_ILL  = 3'b111;

  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_FP   = 11'b00011110011;
  localparam logic [10:0] OP_LOAD = 11'b10101010101;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      enc_word_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic             illegal_c;

  assign in_ready        = (fifo_count < CNT_W'(DEPTH)) && !flush;
  assign out_valid       = (fifo_count != '0);
  assign out_instruction = mem[rd_ptr];
  assign accept_c        = in_valid && in_ready;
  assign illegal_c       = accept_c && (type_instruction == T_ILL);
  assign push_c          = accept_c && (type_instruction != T_ILL);
  assign pop_c           = out_valid && out_ready;

  // Fixed-format field packing per instruction type
  always_comb begin
    enc_word_c = 32'h0000_0000;
    case (type_instruction)
      T_SUB:   enc_word_c = {OP_SUB, regnum_2, shammt, regnum_1, dest_reg};
      T_MUL:   enc_word_c = {OP_MUL, regnum_2, shammt, regnum_1, dest_reg};
      T_ADD:   enc_word_c = {OP_ADD, regnum_2, shammt, regnum_1, dest_reg};
      T_FADD:  enc_word_c = {OP_FP, regnum_2, 6'b001010, regnum_1, dest_reg};
      T_FSUB:  enc_word_c = {OP_FP, regnum_2, 6'b001110, regnum_1, dest_reg};
      T_LOAD:  enc_word_c = {OP_LOAD, address, 2'b00, regnum_1, dest_reg};
      T_NOP:   enc_word_c = 32'h0000_0000;
      default: enc_word_c = 32'h0000_0000;
    endcase
  end

  // Storage array carries no reset; occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= enc_word_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_addr   <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_addr   <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_addr <= out_addr + ADDR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Illegal requests are consumed, flagged for one cycle and counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_pulse <= 1'b0;
      illegal_count <= 8'h00;
    end else begin
      illegal_pulse <= illegal_c;
      if (illegal_c && (illegal_count != 8'hFF))
        illegal_count <= illegal_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_simd_encoder.sv
// Scoreboard bench for simd_encoder: expected words queued at accept,
// compared with address when the DUT hands them out.
module tb_simd_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        type_instruction = '0;
  logic [4:0]        regnum_1 = '0;
  logic [4:0]        regnum_2 = '0;
  logic [4:0]        dest_reg = '0;
  logic [5:0]        shammt = '0;
  logic [8:0]        address = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instruction;
  logic [ADDR_W-1:0] out_addr;
  logic [2:0]        fifo_count;
  logic              illegal_pulse;
  logic [7:0]        illegal_count;

  int unsigned       chk_cnt = 0;
  int unsigned       err_cnt = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;

  simd_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .type_instruction(type_instruction),
    .regnum_1(regnum_1), .regnum_2(regnum_2), .dest_reg(dest_reg),
    .shammt(shammt), .address(address),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_addr(out_addr),
    .fifo_count(fifo_count),
    .illegal_pulse(illegal_pulse), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] t, input logic [4:0] r1,
                                      input logic [4:0] r2, input logic [4:0] rd,
                                      input logic [5:0] sh, input logic [8:0] ad);
    logic [31:0] w;
    w = 32'h0;
    w[9:5] = r1;
    w[4:0] = rd;
    case (t)
      3'd1: begin w[31:21] = 11'b11001011000; w[20:16] = r2; w[15:10] = sh; end
      3'd2: begin w[31:21] = 11'b10011011000; w[20:16] = r2; w[15:10] = sh; end
      3'd3: begin w[31:21] = 11'b10001011000; w[20:16] = r2; w[15:10] = sh; end
      3'd4: begin w[31:21] = 11'b00011110011; w[20:16] = r2; w[15:10] = 6'b001010; end
      3'd5: begin w[31:21] = 11'b00011110011; w[20:16] = r2; w[15:10] = 6'b001110; end
      3'd6: begin w[31:21] = 11'b10101010101; w[20:12] = ad; w[11:10] = 2'b00; end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Output side: compare the head whenever a transfer is about to happen
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        check("word", out_instruction, exp_q.pop_front());
        check("addr", 32'(out_addr), 32'(exp_addr));
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  // One transfer attempt; called and returns at posedge+1
  task automatic send(input logic [2:0] t, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [5:0] sh, input logic [8:0] ad,
                      output bit acc);
    type_instruction = t; regnum_1 = r1; regnum_2 = r2;
    dest_reg = rd; shammt = sh; address = ad; in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    if (acc && t != 3'b111) exp_q.push_back(enc(t, r1, r2, rd, sh, ad));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ill_pulse", 32'(illegal_pulse), 32'(acc && t == 3'b111));
    if (acc && t != 3'b111) check("lat_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic send_rand(output bit acc);
    send(3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 5'($urandom),
         6'($urandom), 9'($urandom), acc);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_addr", 32'(out_addr), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    bit acc;
    int n;
    #12;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_pulse", 32'(illegal_pulse), 32'd0);
    check("rst_illcnt", 32'(illegal_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, held at the head for direct inspection
    out_ready = 1'b0;
    send(3'd3, 5'd1, 5'd2, 5'd3, 6'h00, 9'h000, acc);
    check("add_word", out_instruction, 32'h8B020023);
    check("add_addr", 32'(out_addr), 32'd0);
    drain();
    out_ready = 1'b0;
    send(3'd5, 5'd4, 5'd5, 5'd6, 6'h3F, 9'h000, acc);
    check("fsub_word", out_instruction, 32'h1E653886);
    drain();
    out_ready = 1'b0;
    send(3'd6, 5'd0, 5'd0, 5'd1, 6'h00, 9'h1FF, acc);
    check("load_word", out_instruction, 32'hAABFF001);
    drain();

    // Every legal type, streaming with out_ready high
    for (int t = 0; t < 7; t++) send(3'(t), 5'(t + 7), 5'(t + 11), 5'(t + 19), 6'(t * 9), 9'(t * 73), acc);
    drain();

    // Fill to full, fifth push refused, then drain in order from address 0
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(3'd3, 5'(i), 5'(i + 1), 5'(i + 2), 6'(i), 9'h0, acc);
      check("fill_accept", 32'(acc), 32'(i < 4));
      if (i == 3) begin
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
      end
    end
    drain();

    // Steady push+pop keeps occupancy at one
    out_ready = 1'b1;
    send(3'd1, 5'd1, 5'd1, 5'd1, 6'd1, 9'd0, acc);
    for (int i = 0; i < 4; i++) begin
      send(3'd2, 5'(i), 5'(i), 5'(i), 6'(i), 9'd0, acc);
      check("pushpop_count", 32'(fifo_count), 32'd1);
    end
    drain();

    // Flush with a full FIFO and a simultaneous push attempt
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 5'(i), 5'(i), 5'(i), 6'(i), 9'd0, acc);
    type_instruction = 3'd3; in_valid = 1'b1;
    do_flush();

    // Illegal requests: one pulse each, saturating count, no FIFO write
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(3'b111, 5'd1, 5'd2, 5'd3, 6'd4, 9'd5, acc);
      check("ill_accept", 32'(acc), 32'd1);
      if (i == 9) check("ill_count10", 32'(illegal_count), 32'd10);
    end
    check("ill_count_sat", 32'(illegal_count), 32'd255);
    check("ill_fifo", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    check("ill_pulse_end", 32'(illegal_pulse), 32'd0);
    do_flush();
    check("ill_count_kept", 32'(illegal_count), 32'd255);

    // Random stream long enough to wrap the 8-bit output address
    n = 0;
    for (int i = 0; i < 2000 && n < 280; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send_rand(acc);
      if (acc) n++;
    end
    check("rand_pushes", 32'(n), 32'd280);
    drain();
    check("wrap_addr", 32'(out_addr), 32'(8'(280)));

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(acc);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_illcnt", 32'(illegal_count), 32'd0);
    exp_q.delete();
    exp_addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'd2, 5'd9, 5'd10, 5'd11, 6'd12, 9'd0, acc);
    check("post_rst_addr", 32'(out_addr), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/simd_encoder.md
SIMD_ENCODER -- requirements
Module: simd_encoder

Interface
REQ-001 Parameter DEPTH, default 4, the number of encoded-word FIFO entries, which SHALL be a power of two and at least 2.
REQ-002 Parameter ADDR_W, default 8, the width of the instruction write address.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 Port flush, input, 1, a synchronous clear of the FIFO and the address counter.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1) SHALL form the field-input handshake.
REQ-007 Port type_instruction, input, 3: 000 NOP, 001 SUB, 010 MUL, 011 ADD, 100 FADD, 101 FSUB, 110 LOAD, 111 illegal.
REQ-008 Ports regnum_1 (input, 5), regnum_2 (input, 5), dest_reg (input, 5), shammt (input, 6) and address (input, 9) SHALL carry the operand fields.
REQ-009 Ports out_valid (output, 1) and out_ready (input, 1) SHALL form the encoded-word handshake.
REQ-010 Port out_instruction, output, 32, the encoded word at the FIFO head.
REQ-011 Port out_addr, output, ADDR_W, the instruction-memory address paired with out_instruction.
REQ-012 Port fifo_count, output, clog2(DEPTH)+1, the current FIFO occupancy.
REQ-013 Port illegal_pulse, output, 1, a one-cycle flag that an illegal type was dropped.
REQ-014 Port illegal_count, output, 8, a saturating count of dropped illegal requests.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal (fifo_count < DEPTH) AND NOT flush, with no same-cycle bypass when the FIFO is full.
REQ-016 Encoding SHALL be fixed per type:
- R-type (SUB/MUL/ADD): [31:21]=opcode, [20:16]=regnum_2, [15:10]=shammt, [9:5]=regnum_1, [4:0]=dest_reg.
- Opcodes: SUB 11001011000, MUL 10011011000, ADD 10001011000.
REQ-017 FADD and FSUB SHALL encode [31:21]=00011110011 with [15:10] forced to 001010 (FADD) or 001110 (FSUB), ignoring shammt; all other fields SHALL be as R-type.
REQ-018 LOAD SHALL encode [31:21]=10101010101, [20:12]=address, [11:10]=00, [9:5]=regnum_1, [4:0]=dest_reg.
REQ-019 NOP SHALL encode 32'h00000000, with all fields ignored.
REQ-020 Type 111 SHALL be handled as follows:
- It is consumed per REQ-015 but not written to the FIFO.
- illegal_pulse is high for exactly the next cycle.
- illegal_count increments and saturates at 255.
REQ-021 An accepted legal word SHALL be written at the tail; out_valid SHALL be high whenever fifo_count is nonzero, so latency from accept to out_valid is 1 cycle.
REQ-022 out_instruction and out_addr SHALL be held stable while out_valid is high and out_ready is low.
REQ-023 An output transfer (out_valid AND out_ready) SHALL pop the head and increment out_addr modulo 2^ADDR_W, wrapping from all-ones to 0.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged, and the FIFO SHALL preserve order.
REQ-025 A pop on an empty FIFO SHALL not be possible because out_valid is low; a push when full SHALL not be possible because in_ready is low.
REQ-026 Flush SHALL take priority over a same-cycle push or pop: the next cycle has fifo_count=0 and out_addr=0, and illegal_count is retained.
REQ-027 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst_n is low, the block SHALL hold fifo_count=0, out_valid=0, out_addr=0, illegal_pulse=0, illegal_count=0 and the pointers at 0, with in_ready=1 once flush is low.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents immediately and asynchronously.
REQ-030 After rst_n deasserts, the first accepted word SHALL appear on the next cycle with out_addr=0.

Verification
REQ-031 ADD with rd=3, rs1=1, rs2=2, shammt=0 -> out_instruction=32'h8B020023 and out_addr=0 one cycle later.
REQ-032 FSUB with shammt=6'h3F, rs1=4, rs2=5, rd=6 -> [15:10]=001110, word=32'h1E653886.
REQ-033 LOAD with address=9'h1FF, rs1=0, rd=1 -> word=32'hAABFF001.
REQ-034 Five back-to-back pushes with out_ready=0 -> in_ready falls after the 4th, fifo_count=4; then out_ready=1 drains them in order with out_addr 0,1,2,3.
REQ-035 Type 111 pushed 300 times -> no FIFO write, illegal_pulse once per request, illegal_count=255.
REQ-036 A flush and a push in the same cycle with a full FIFO -> fifo_count=0 and out_addr=0 next cycle, and the word is not accepted.
